// File: rtl/heater_sequencer.sv
// Soft-start/soft-stop sequencer for a heater array, with per-heater error clear
// pulses, sticky error flags, a saturating error total and a latched fault shutdown.
module heater_sequencer #(
  parameter int N           = 32,
  parameter int STEP_CYCLES = 1024,
  parameter int ERR_LIMIT   = 16,
  parameter int CW          = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   stop,
  input  logic [$clog2(N+1)-1:0] target,
  input  logic                   fault_clear,
  input  logic [N-1:0]           sticky_clear,
  input  logic [N-1:0]           heater_error,
  output logic [N-1:0]           heater_enable,
  output logic [N-1:0]           heater_err_clear,
  output logic [$clog2(N+1)-1:0] en_count,
  output logic [2:0]             state,
  output logic [N-1:0]           err_sticky,
  output logic [CW-1:0]          err_total,
  output logic                   fault
);

  localparam int NW = $clog2(N+1);
  localparam int TW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam int SW = ((CW > NW) ? CW : NW) + 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(STEP_CYCLES - 1);
  localparam logic [NW-1:0] N_VAL      = NW'(N);
  localparam logic [SW-1:0] TOTAL_MAX  = (SW'(1) << CW) - SW'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_UP    = 3'd1,
    S_RUN   = 3'd2,
    S_DOWN  = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  state_t          r_state;
  logic [TW-1:0]   r_timer;
  logic [NW-1:0]   r_en_count;
  logic            r_stop_pending;
  logic            r_fault_pending;
  logic            r_fault;
  logic [N-1:0]    r_clear_pending;
  logic [N-1:0]    r_err_clear;
  logic [N-1:0]    r_err_sticky;
  logic [CW-1:0]   r_err_total;

  logic [NW-1:0]   w_tgt;
  logic [NW-1:0]   w_goal;
  logic [NW-1:0]   w_inc;
  logic [NW-1:0]   w_dec;
  logic            w_wrap;
  logic            w_down_done;
  logic            w_limit_hit;
  logic [N-1:0]    w_new_err;
  logic [NW-1:0]   w_new_cnt;
  logic [SW-1:0]   w_sum;
  state_t          w_done_state;

  assign w_tgt       = (target > N_VAL) ? N_VAL : target;
  assign w_goal      = (r_stop_pending || r_fault_pending) ? '0 : w_tgt;
  assign w_inc       = r_en_count + NW'(1);
  assign w_dec       = r_en_count - NW'(1);
  assign w_wrap      = (r_timer == TIMER_LAST);
  assign w_down_done = (r_en_count == w_goal) || (w_wrap && (w_dec == w_goal));
  assign w_new_err   = heater_error & ~r_clear_pending;
  assign w_sum       = SW'(r_err_total) + SW'(w_new_cnt);
  assign w_limit_hit = (ERR_LIMIT > 0) && (32'(r_err_total) >= 32'(ERR_LIMIT))
                       && (r_state != S_FAULT) && !r_fault_pending;
  assign w_done_state = (w_goal != '0) ? S_RUN : (r_fault_pending ? S_FAULT : S_IDLE);

  always_comb begin
    w_new_cnt = '0;
    for (int i = 0; i < N; i++) begin
      w_new_cnt = w_new_cnt + NW'(w_new_err[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= S_IDLE;
      r_timer         <= '0;
      r_en_count      <= '0;
      r_stop_pending  <= 1'b0;
      r_fault_pending <= 1'b0;
      r_fault         <= 1'b0;
      r_clear_pending <= '0;
      r_err_clear     <= '0;
      r_err_sticky    <= '0;
      r_err_total     <= '0;
    end else begin
      // A held error only re-arms once the flag has been seen low.
      r_clear_pending <= heater_error;
      r_err_clear     <= w_new_err;
      r_err_sticky    <= (r_err_sticky & ~sticky_clear) | w_new_err;
      if (fault_clear) begin
        r_err_total <= '0;
      end else if (w_sum > TOTAL_MAX) begin
        r_err_total <= '1;
      end else begin
        r_err_total <= w_sum[CW-1:0];
      end

      if (w_limit_hit) begin
        r_state         <= S_DOWN;
        r_timer         <= '0;
        r_fault_pending <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start && !stop && (w_tgt != '0)) begin
              r_state <= S_UP;
              r_timer <= '0;
            end
          end
          S_UP: begin
            if (stop) begin
              r_state        <= S_DOWN;
              r_timer        <= '0;
              r_stop_pending <= 1'b1;
            end else if (w_tgt < r_en_count) begin
              r_state <= S_DOWN;
              r_timer <= '0;
            end else if (w_tgt == r_en_count) begin
              r_state <= S_RUN;
            end else begin
              r_timer <= w_wrap ? '0 : r_timer + TW'(1);
              if (w_wrap) begin
                r_en_count <= w_inc;
                if (w_inc == w_tgt) r_state <= S_RUN;
              end
            end
          end
          S_RUN: begin
            if (stop) begin
              r_state        <= S_DOWN;
              r_timer        <= '0;
              r_stop_pending <= 1'b1;
            end else if (w_tgt > r_en_count) begin
              r_state <= S_UP;
              r_timer <= '0;
            end else if (w_tgt < r_en_count) begin
              r_state <= S_DOWN;
              r_timer <= '0;
            end
          end
          S_DOWN: begin
            if (stop) begin
              r_timer        <= '0;
              r_stop_pending <= 1'b1;
            end else if (!r_stop_pending && !r_fault_pending && (w_tgt > r_en_count)) begin
              r_state <= S_UP;
              r_timer <= '0;
            end else begin
              if (r_en_count != w_goal) begin
                r_timer <= w_wrap ? '0 : r_timer + TW'(1);
                if (w_wrap) r_en_count <= w_dec;
              end
              // Reaching goal 0 ends any stop/fault ramp; fault latches here.
              if (w_down_done) begin
                r_state <= w_done_state;
                if (w_goal == '0) begin
                  r_stop_pending  <= 1'b0;
                  r_fault_pending <= 1'b0;
                  r_fault         <= r_fault_pending;
                end
              end
            end
          end
          S_FAULT: begin
            if (fault_clear) begin
              r_state <= S_IDLE;
              r_fault <= 1'b0;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_enable
      assign heater_enable[gi] = (r_en_count > NW'(gi));
    end
  endgenerate

  assign heater_err_clear = r_err_clear;
  assign en_count         = r_en_count;
  assign state            = r_state;
  assign err_sticky       = r_err_sticky;
  assign err_total        = r_err_total;
  assign fault            = r_fault;

endmodule

// File: doc/heater_sequencer.md
Name: heater_sequencer

Overview:
- Controls the array of heater instances: soft-starts and soft-stops their enables one heater at a time, which limits supply current steps.
- Services heater errors: pulses each heater's err_clear, keeps sticky per-heater error flags and counts total errors.
- Forces a controlled shutdown and latched fault when the error budget is exceeded.
- Sits between the processor GPIO/control registers and the heater_enable / heater_err_clear / heater_error vectors. All inputs are synchronous to clk; the caller synchronizes them.

Parameters:
- N, 32, number of heater instances.
- STEP_CYCLES, 1024, clk cycles between successive enable/disable steps; must be >= 1.
- ERR_LIMIT, 16, total error count that triggers a fault; 0 disables fault detection.
- CW, 16, width of err_total.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begin or resume sequencing toward target.
- stop  in  1  one-cycle pulse; ramp all heaters off.
- target  in  $clog2(N+1)  number of heaters to run; values > N are clamped to N.
- fault_clear  in  1  one-cycle pulse; exit FAULT and zero err_total.
- sticky_clear  in  N  write-1-to-clear mask for err_sticky.
- heater_error  in  N  per-heater error flag; held high until cleared.
- heater_enable  out  N  thermometer-coded enables; bit i is high iff i < en_count.
- heater_err_clear  out  N  per-heater one-cycle clear pulse.
- en_count  out  $clog2(N+1)  number of heaters currently enabled.
- state  out  3  IDLE=0, UP=1, RUN=2, DOWN=3, FAULT=4.
- err_sticky  out  N  latched per-heater error seen.
- err_total  out  CW  saturating count of clears issued.
- fault  out  1  high in FAULT state.

Behaviour:
- Reset: all outputs 0; state=IDLE; step timer=0; clear_pending=0.
- Step timer: counts 0..STEP_CYCLES-1 while in UP or DOWN. A step happens on the wrap. The timer restarts at 0 on every state entry. The first step is therefore STEP_CYCLES cycles after entering UP or DOWN.
- UP step: en_count+1 (lowest disabled index turns on first).
- DOWN step: en_count-1 (highest enabled index turns off first).
- Let tgt = min(target, N); goal = tgt, or 0 after stop or fault.
- IDLE:
  - start with tgt>0 -> UP.
  - start with tgt=0 is ignored.
- UP:
  - When en_count reaches tgt -> RUN.
  - If tgt drops below en_count -> DOWN.
- RUN:
  - tgt>en_count -> UP.
  - tgt<en_count -> DOWN.
  - target is resampled every cycle.
- DOWN:
  - When en_count reaches goal -> RUN if goal>0, IDLE if goal=0.
  - If tgt rises above en_count and no stop is pending -> UP.
- stop in UP, RUN or DOWN: goal=0, enter DOWN with the timer restarted. A stop pending flag holds until IDLE.
- stop and start in the same cycle: stop wins.
- start while a stop is pending is ignored.
- Error servicing, per bit, in every state:
  - If heater_error[i]=1 and clear_pending[i]=0: next cycle heater_err_clear[i]=1 for exactly one cycle; clear_pending[i]=1; err_sticky[i]=1; err_total increments.
  - clear_pending[i] returns to 0 when heater_error[i] is sampled 0. This prevents repeated clears on an error held for several cycles.
- Multiple bits erroring in the same cycle: err_total increments by the popcount of new clears, saturating at 2^CW-1.
- err_sticky set and sticky_clear on the same bit in the same cycle: set wins.
- Fault:
  - When ERR_LIMIT>0 and err_total>=ERR_LIMIT, from any state except FAULT: goal=0, enter DOWN with fault_pending set.
  - When en_count reaches 0 -> FAULT and fault=1.
  - In FAULT, start is ignored and enables stay 0.
  - fault_clear: err_total=0, fault=0, state=IDLE.
  - fault_clear outside FAULT: only zeroes err_total.
- Fault detection has priority over start, stop and target changes.
- Reset mid-ramp: enables drop to 0 the next cycle (no ramp).

Test Plan:
- N=8, STEP_CYCLES=4, target=5, start pulse -> en_count steps 1..5 at 4-cycle intervals; heater_enable=0x1F; state=RUN 20 cycles after start.
- In RUN at 5, stop pulse -> heater_enable goes 0x0F, 0x07, 0x03, 0x01, 0x00 at 4-cycle intervals; state=IDLE; a start in the same cycle as stop is ignored.
- In RUN at 5, set target=2, then later target=7 -> DOWN to 0x03, RUN, then UP to 0x7F.
- heater_error[3] high for 10 cycles -> exactly one heater_err_clear[3] pulse one cycle later; err_sticky=0x08; err_total=1. Error bits 1 and 6 in the same cycle -> err_total+=2.
- ERR_LIMIT=3, three errors while at 5 enabled -> ramp to 0 in 5 steps; state=FAULT, fault=1; start ignored; fault_clear -> IDLE, err_total=0.
- target=9 with N=8 -> clamps to 8, heater_enable=0xFF. Reset asserted mid-UP -> all outputs 0 the next cycle.
